sec_pulse_gen: RTL and testbench

//  Programmable second-pulse (PPS) generator: the transmitting end of the sec_pulse line that the

---
 rtl/sec_pulse_gen.sv | 171 +++++++++++++++++
 tb/tb_sec_pulse_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sec_pulse_gen.sv
// Programmable pulse-per-second generator: start delay, width, period, one-shot slew, shadowed reconfig.
// Optional SEC_PULSE_SYNC_EN: a synchronized sync_in rising edge forces an immediate period restart.
module sec_pulse_gen #(
  parameter int CNT_W = 32,
  parameter int WID_W = 24,
  parameter int ADJ_W = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [WID_W-1:0]        cfg_width,
  input  logic [CNT_W-1:0]        cfg_delay,
  input  logic                    cfg_load,
  input  logic signed [ADJ_W-1:0] adj_val,
  input  logic                    adj_stb,
  input  logic                    sync_in,
  output logic                    pulse_out,
  output logic                    pulse_ed,
  output logic [CNT_W-1:0]        sec_cnt,
  output logic [1:0]              state
);
  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, HIGH = 2'd2, LOW = 2'd3} state_e;
  localparam int SUM_W = CNT_W + 2;

  state_e                  state_q;
  logic                    pulse_q, ed_q;
  logic [CNT_W-1:0]        sec_q, cnt_q, per_q, wid_q;
  logic [CNT_W-1:0]        sh_p_q, sh_d_q, pd_p_q, pd_d_q;
  logic [WID_W-1:0]        sh_w_q, pd_w_q;
  logic                    pd_vld_q;
  logic signed [ADJ_W-1:0] adj_q;

  logic [CNT_W-1:0]        p_sel, p_base, w_eff, p_eff;
  logic [WID_W-1:0]        w_sel;
  logic                    sync_hit, go_idle, bound;

  function automatic logic [CNT_W-1:0] clamp_base(input logic [CNT_W-1:0] p);
    return (p < CNT_W'(2)) ? CNT_W'(2) : p;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_width(input logic [WID_W-1:0] w,
                                                   input logic [CNT_W-1:0] p);
    logic [CNT_W-1:0] wx;
    wx = (w == '0) ? CNT_W'(1) : CNT_W'(w);
    return (wx >= p) ? p - CNT_W'(1) : wx;
  endfunction

  // Slewed period must still leave at least one low cycle after the pulse; never wraps.
  function automatic logic [CNT_W-1:0] sat_period(input logic [CNT_W-1:0]        p,
                                                  input logic signed [ADJ_W-1:0] adj,
                                                  input logic [CNT_W-1:0]        w);
    logic signed [SUM_W-1:0] sum, floor_v, ceil_v;
    sum     = $signed({2'b00, p}) + SUM_W'(adj);
    floor_v = $signed({2'b00, w}) + SUM_W'(1);
    ceil_v  = $signed({2'b00, {CNT_W{1'b1}}});
    if (sum < floor_v) return w + CNT_W'(1);
    if (sum > ceil_v)  return '1;
    return sum[CNT_W-1:0];
  endfunction

  always_comb begin
    p_sel  = pd_vld_q ? pd_p_q : sh_p_q;
    w_sel  = pd_vld_q ? pd_w_q : sh_w_q;
    p_base = clamp_base(p_sel);
    w_eff  = clamp_width(w_sel, p_base);
    p_eff  = sat_period(p_base, adj_q, w_eff);
  end

  assign go_idle = (state_q != IDLE) && !enable;
  assign bound   = ((state_q == DELAY) && (cnt_q >= sh_d_q)) ||
                   ((state_q == LOW)   && (cnt_q >= per_q));

`ifdef SEC_PULSE_SYNC_EN
  logic [2:0] sync_q;
  logic       sync_ed_q;

  // Two synchronizer flops, one history flop, and a registered edge strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q    <= '0;
      sync_ed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[1:0], sync_in};
      sync_ed_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign sync_hit = sync_ed_q;
`else
  logic unused_sync;
  assign unused_sync = sync_in;
  assign sync_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      pulse_q  <= 1'b0;
      ed_q     <= 1'b0;
      sec_q    <= '0;
      cnt_q    <= '0;
      per_q    <= CNT_W'(2);
      wid_q    <= CNT_W'(1);
      sh_p_q   <= CNT_W'(2);
      sh_w_q   <= WID_W'(1);
      sh_d_q   <= '0;
      pd_p_q   <= '0;
      pd_w_q   <= '0;
      pd_d_q   <= '0;
      pd_vld_q <= 1'b0;
      adj_q    <= '0;
    end else begin
      ed_q <= 1'b0;
      if (state_q == IDLE) begin
        if (enable) begin
          state_q <= DELAY;
          cnt_q   <= '0;
        end
      end else if (!enable) begin
        state_q <= IDLE;
        pulse_q <= 1'b0;
      end else if (sync_hit || bound) begin
        // Period boundary: commit pending config and consume the one-shot slew.
        state_q <= HIGH;
        pulse_q <= 1'b1;
        ed_q    <= 1'b1;
        sec_q   <= sec_q + CNT_W'(1);
        cnt_q   <= CNT_W'(1);
        per_q   <= p_eff;
        wid_q   <= w_eff;
        adj_q   <= '0;
        if (pd_vld_q) begin
          sh_p_q   <= pd_p_q;
          sh_w_q   <= pd_w_q;
          sh_d_q   <= pd_d_q;
          pd_vld_q <= 1'b0;
        end
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
        if ((state_q == HIGH) && (cnt_q >= wid_q)) begin
          state_q <= LOW;
          pulse_q <= 1'b0;
        end
      end

      if (go_idle)      adj_q <= '0;
      else if (adj_stb) adj_q <= adj_val;

      if (cfg_load) begin
        if (state_q == IDLE) begin
          sh_p_q   <= cfg_period;
          sh_w_q   <= cfg_width;
          sh_d_q   <= cfg_delay;
          pd_vld_q <= 1'b0;
        end else begin
          pd_p_q   <= cfg_period;
          pd_w_q   <= cfg_width;
          pd_d_q   <= cfg_delay;
          pd_vld_q <= 1'b1;
        end
      end
    end
  end

  assign pulse_out = pulse_q;
  assign pulse_ed  = ed_q;
  assign sec_cnt   = sec_q;
  assign state     = state_q;

endmodule

// File: tb/tb_sec_pulse_gen.sv
// Bench for sec_pulse_gen: table of configurations plus hand sequences for shadowing, slew, disable and reset.
module tb_sec_pulse_gen;
  localparam int CNT_W = 32;
  localparam int WID_W = 24;
  localparam int ADJ_W = 16;

  logic                    clk = 1'b0;
  logic                    resetn = 1'b0;
  logic                    enable = 1'b0;
  logic [CNT_W-1:0]        cfg_period = '0;
  logic [WID_W-1:0]        cfg_width = '0;
  logic [CNT_W-1:0]        cfg_delay = '0;
  logic                    cfg_load = 1'b0;
  logic signed [ADJ_W-1:0] adj_val = '0;
  logic                    adj_stb = 1'b0;
  logic                    sync_in = 1'b0;
  logic                    pulse_out, pulse_ed;
  logic [CNT_W-1:0]        sec_cnt;
  logic [1:0]              state;

  typedef struct { int p; int w; int d; int first; int hi; int per; } vec_t;
  typedef struct { int first; int hi; int per; } exp_t;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   ed_err = 0;
  int   rise_at = 0;
  logic prev_po = 1'b0;
  int   rise_q[$];
  int   hi_q[$];
  exp_t sb[$];

  sec_pulse_gen #(.CNT_W(CNT_W), .WID_W(WID_W), .ADJ_W(ADJ_W)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .cfg_period(cfg_period), .cfg_width(cfg_width), .cfg_delay(cfg_delay), .cfg_load(cfg_load),
    .adj_val(adj_val), .adj_stb(adj_stb), .sync_in(sync_in),
    .pulse_out(pulse_out), .pulse_ed(pulse_ed), .sec_cnt(sec_cnt), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pulse_out && !prev_po) begin
      rise_q.push_back(cyc);
      rise_at = cyc;
      if (!pulse_ed) ed_err++;
    end else if (pulse_ed) begin
      ed_err++;
    end
    if (!pulse_out && prev_po) hi_q.push_back(cyc - rise_at);
    prev_po = pulse_out;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input int p, input int w, input int d);
    cfg_period = CNT_W'(p);
    cfg_width  = WID_W'(w);
    cfg_delay  = CNT_W'(d);
    cfg_load   = 1'b1;
    tick(1);
    cfg_load   = 1'b0;
  endtask

  task automatic strobe_adj(input int a);
    adj_val = ADJ_W'(a);
    adj_stb = 1'b1;
    tick(1);
    adj_stb = 1'b0;
  endtask

  task automatic clr();
    rise_q.delete();
    hi_q.delete();
  endtask

  task automatic wait_rises(input int n, input int budget);
    int k = 0;
    while (rise_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (rise_q.size() < n) check("rise_timeout", rise_q.size(), n);
  endtask

  function automatic int rq(input int i);
    return (i < rise_q.size()) ? rise_q[i] : -1;
  endfunction

  function automatic int hq(input int i);
    return (i < hi_q.size()) ? hi_q[i] : -1;
  endfunction

  initial begin
    vec_t vecs[5];
    exp_t e;
    int   e0, sc0;
    vecs[0] = '{1000,   50, 10, 11,  50, 1000};
    vecs[1] = '{   1,    0,  0,  1,   1,    2};
    vecs[2] = '{1000, 1200,  3,  4, 999, 1000};
    vecs[3] = '{  20,    5,  0,  1,   5,   20};
    vecs[4] = '{   2,    1,  7,  8,   1,    2};

    tick(3);
    check("rst_pulse_out", int'(pulse_out), 0);
    check("rst_pulse_ed", int'(pulse_ed), 0);
    check("rst_sec_cnt", int'(sec_cnt), 0);
    check("rst_state", int'(state), 0);
    resetn = 1'b1;
    tick(1);

    // Reset shadow values: P=2, W=1, D=0.
    clr();
    enable = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    wait_rises(3, 50);
    check("dflt_seccnt", int'(sec_cnt), 3);
    check("dflt_first", rq(0) - e0, 1);
    check("dflt_period", rq(2) - rq(1), 2);
    check("dflt_high", hq(0), 1);

    foreach (vecs[i]) begin
      enable = 1'b0;
      tick(2);
      load_cfg(vecs[i].p, vecs[i].w, vecs[i].d);
      sb.push_back('{vecs[i].first, vecs[i].hi, vecs[i].per});
      clr();
      sc0 = int'(sec_cnt);
      enable = 1'b1;
      @(posedge clk); #1;
      e0 = cyc;
      wait_rises(3, 3 * vecs[i].per + vecs[i].d + 20);
      check($sformatf("v%0d_seccnt", i), int'(sec_cnt), sc0 + 3);
      e = sb.pop_front();
      check($sformatf("v%0d_first", i), rq(0) - e0, e.first);
      check($sformatf("v%0d_high", i), hq(0), e.hi);
      check($sformatf("v%0d_period1", i), rq(1) - rq(0), e.per);
      check($sformatf("v%0d_period2", i), rq(2) - rq(1), e.per);
    end

    // Shadowed reload mid-LOW takes effect at the following boundary.
    enable = 1'b0; tick(2);
    load_cfg(1000, 50, 0);
    clr();
    enable = 1'b1;
    wait_rises(1, 20);
    tick(100);
    load_cfg(500, 50, 0);
    wait_rises(3, 2000);
    check("shadow_cur_period", rq(1) - rq(0), 1000);
    check("shadow_new_period", rq(2) - rq(1), 500);

    // One-shot slew, last strobe wins, same-clock load+slew, slew floor.
    enable = 1'b0; tick(2);
    load_cfg(1000, 50, 0);
    clr();
    enable = 1'b1;
    wait_rises(1, 20);
    tick(100);
    strobe_adj(-100);
    wait_rises(4, 3500);
    check("adj_before", rq(1) - rq(0), 1000);
    check("adj_applied", rq(2) - rq(1), 900);
    check("adj_once", rq(3) - rq(2), 1000);
    tick(100);
    strobe_adj(7);
    tick(5);
    strobe_adj(-3);
    wait_rises(6, 2500);
    check("adj_wait", rq(4) - rq(3), 1000);
    check("adj_last_wins", rq(5) - rq(4), 997);
    tick(100);
    cfg_period = CNT_W'(600); cfg_width = WID_W'(50); cfg_delay = '0;
    adj_val = ADJ_W'(-50);
    cfg_load = 1'b1; adj_stb = 1'b1;
    tick(1);
    cfg_load = 1'b0; adj_stb = 1'b0;
    wait_rises(9, 3000);
    check("ldadj_cur", rq(6) - rq(5), 1000);
    check("ldadj_combined", rq(7) - rq(6), 550);
    check("ldadj_after", rq(8) - rq(7), 600);
    tick(100);
    strobe_adj(-1000);
    wait_rises(11, 1500);
    check("adj_floor", rq(10) - rq(9), 51);

    // Disable during HIGH with a slew pending, then re-enable.
    enable = 1'b0; tick(2);
    load_cfg(20, 10, 0);
    clr();
    enable = 1'b1;
    wait_rises(1, 20);
    strobe_adj(-5);
    sc0 = int'(sec_cnt);
    check("dis_pre_high", int'(pulse_out), 1);
    enable = 1'b0;
    tick(1);
    check("dis_pulse_out", int'(pulse_out), 0);
    check("dis_state", int'(state), 0);
    check("dis_seccnt", int'(sec_cnt), sc0);
    clr();
    enable = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    wait_rises(2, 60);
    check("reen_first", rq(0) - e0, 1);
    check("reen_adj_cleared", rq(1) - rq(0), 20);

    // Asynchronous reset while in LOW.
    tick(12);
    check("rst_pre_low", int'(state), 3);
    resetn = 1'b0;
    #2;
    check("arst_pulse_out", int'(pulse_out), 0);
    check("arst_pulse_ed", int'(pulse_ed), 0);
    check("arst_sec_cnt", int'(sec_cnt), 0);
    check("arst_state", int'(state), 0);
    tick(2);
    resetn = 1'b1;
    clr();
    wait_rises(3, 30);
    check("arst_shadow_period", rq(2) - rq(1), 2);
    check("arst_seccnt", int'(sec_cnt), 3);

`ifdef SEC_PULSE_SYNC_EN
    enable = 1'b0; tick(2);
    load_cfg(1000, 50, 0);
    clr();
    enable = 1'b1;
    wait_rises(1, 20);
    tick(400);
    sync_in = 1'b1;
    e0 = cyc;
    tick(5);
    sync_in = 1'b0;
    wait_rises(3, 2000);
    check("sync_rise", rq(1) - e0, 4);
    check("sync_next", rq(2) - rq(1), 1000);
`endif

    check("pulse_ed_align", ed_err, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
